phy_mgmt_arbiter: RTL



---
 rtl/phy_mgmt_pkg.sv | 20 ++
 rtl/rr_grant.sv | 35 +++
 rtl/phy_mgmt_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/phy_mgmt_pkg.sv
`default_nettype none
//==============================================================================
// Module : phy_mgmt_pkg
// Brief  : Shared defaults and state encoding for the PHY management arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
package phy_mgmt_pkg;

    localparam int c_def_addr_w  = 9;
    localparam int c_def_data_w  = 32;
    localparam int c_def_timeout = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage : phy_mgmt_pkg
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
//==============================================================================
// Module : rr_grant
// Brief  : Combinational rotate-priority picker; searches last+1, last+2, ...
// Rev    : 1.0 - initial release
//==============================================================================
module rr_grant #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_index,
    output logic             o_any
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_grant = '0;
        o_index = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && i_req[(int'(i_last) + k) % N]) begin
                w_found                            = 1'b1;
                o_grant[(int'(i_last) + k) % N]    = 1'b1;
                o_index                            = IDX_W'((int'(i_last) + k) % N);
            end
        end
        o_any = w_found;
    end

endmodule : rr_grant
`default_nettype wire

// File: rtl/phy_mgmt_arbiter.sv
`default_nettype none
//==============================================================================
// Module : phy_mgmt_arbiter
// Brief  : Round-robin arbiter sharing one PHY management Avalon-MM port.
// Rev    : 1.0 - initial release
//==============================================================================
module phy_mgmt_arbiter
    import phy_mgmt_pkg::*;
#(
    parameter int N       = 3,
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0]        req_write,
    input  logic [N*ADDR_W-1:0] req_address,
    input  logic [N*DATA_W-1:0] req_writedata,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        resp_valid,
    output logic [DATA_W-1:0]   resp_readdata,
    output logic                resp_error,
    output logic                busy,
    output logic [ADDR_W-1:0]   mgmt_address,
    output logic                mgmt_read,
    output logic                mgmt_write,
    output logic [DATA_W-1:0]   mgmt_writedata,
    input  logic [DATA_W-1:0]   mgmt_readdata,
    input  logic                mgmt_waitrequest
);

    localparam int                 c_idx_w    = $clog2(N);
    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t               r_state,  w_state_nx;
    logic [c_idx_w-1:0]   r_last,   w_last_nx;
    logic [c_idx_w-1:0]   r_gidx,   w_gidx_nx;
    logic [N-1:0]         r_grant,  w_grant_nx;
    logic [c_cnt_w-1:0]   r_count,  w_count_nx;
    logic [ADDR_W-1:0]    r_addr,   w_addr_nx;
    logic [DATA_W-1:0]    r_wdata,  w_wdata_nx;
    logic                 r_rd,     w_rd_nx;
    logic                 r_wr,     w_wr_nx;
    logic [N-1:0]         r_ready,  w_ready_nx;
    logic [N-1:0]         r_rvalid, w_rvalid_nx;
    logic [DATA_W-1:0]    r_rdata,  w_rdata_nx;
    logic                 r_err,    w_err_nx;
    logic                 r_busy;

    logic [N-1:0]         w_pick;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_pick_any;

    rr_grant #(
        .N     (N),
        .IDX_W (c_idx_w)
    ) u_rr_grant (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_index (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_last_nx   = r_last;
        w_gidx_nx   = r_gidx;
        w_grant_nx  = r_grant;
        w_count_nx  = r_count;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_rd_nx     = r_rd;
        w_wr_nx     = r_wr;
        w_ready_nx  = '0;
        w_rvalid_nx = '0;
        w_rdata_nx  = r_rdata;
        w_err_nx    = r_err;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gidx_nx  = w_pick_idx;
                    w_grant_nx = w_pick;
                    w_addr_nx  = req_address[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                    w_wdata_nx = req_writedata[int'(w_pick_idx)*DATA_W +: DATA_W];
                    w_wr_nx    = req_write[w_pick_idx];
                    w_rd_nx    = !req_write[w_pick_idx];
                    w_ready_nx = w_pick;
                    w_count_nx = '0;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                // Completion wins over timeout when both land in the same cycle.
                if (!mgmt_waitrequest) begin
                    w_rd_nx     = 1'b0;
                    w_wr_nx     = 1'b0;
                    w_rdata_nx  = r_wr ? '0 : mgmt_readdata;
                    w_err_nx    = 1'b0;
                    w_rvalid_nx = r_grant;
                    w_state_nx  = RESP;
                end else if (r_count == c_cnt_last) begin
                    w_rd_nx     = 1'b0;
                    w_wr_nx     = 1'b0;
                    w_rdata_nx  = '0;
                    w_err_nx    = 1'b1;
                    w_rvalid_nx = r_grant;
                    w_state_nx  = RESP;
                end else begin
                    w_count_nx  = r_count + 1'b1;
                end
            end
            RESP: begin
                w_last_nx  = r_gidx;
                w_count_nx = '0;
                w_rdata_nx = '0;
                w_err_nx   = 1'b0;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= c_idx_w'(N - 1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_ready  <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_last   <= w_last_nx;
            r_gidx   <= w_gidx_nx;
            r_grant  <= w_grant_nx;
            r_count  <= w_count_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_rd     <= w_rd_nx;
            r_wr     <= w_wr_nx;
            r_ready  <= w_ready_nx;
            r_rvalid <= w_rvalid_nx;
            r_rdata  <= w_rdata_nx;
            r_err    <= w_err_nx;
            r_busy   <= (w_state_nx != IDLE);
        end
    end

    assign req_ready      = r_ready;
    assign resp_valid     = r_rvalid;
    assign resp_readdata  = r_rdata;
    assign resp_error     = r_err;
    assign busy           = r_busy;
    assign mgmt_address   = r_addr;
    assign mgmt_read      = r_rd;
    assign mgmt_write     = r_wr;
    assign mgmt_writedata = r_wdata;

endmodule : phy_mgmt_arbiter
`default_nettype wire
